// File: rtl/l1_flatten_if.sv
// Memory-side bus of the layer-1 flatten stage: one shared bank select,
// a read port whose data returns the cycle after crd, and a write port.
interface l1_flatten_if #(
    parameter int DW = 20,
    parameter int AW = 12
);
    logic                 crd;
    logic [AW-1:0]        caddr_rd;
    logic signed [DW-1:0] cdata_rd;
    logic                 cwr;
    logic [AW-1:0]        caddr_wr;
    logic signed [DW-1:0] cdata_wr;
    logic [2:0]           csel;

    modport master (
        output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        input  cdata_rd
    );

    modport slave (
        input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        output cdata_rd
    );
endinterface

// File: rtl/l1_flatten.sv
// Reads both pooled kernel maps back from layer-1 memory and writes them
// interleaved into layer-2 memory, tracking the global maximum on the way.
module l1_flatten #(
    parameter int         MAP_PIX = 1024,
    parameter int         DW      = 20,
    parameter int         AW      = 12,
    parameter logic [2:0] SEL_K0  = 3'd3,
    parameter logic [2:0] SEL_K1  = 3'd4,
    parameter logic [2:0] SEL_OUT = 3'd5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic signed [DW-1:0] max_val,
    output logic [AW-1:0]        max_idx,
    l1_flatten_if.master         mem
);

    localparam int IW = $clog2(MAP_PIX);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_A  = 3'd1;
    localparam logic [2:0] CAP_A = 3'd2;
    localparam logic [2:0] WR_A  = 3'd3;
    localparam logic [2:0] RD_B  = 3'd4;
    localparam logic [2:0] CAP_B = 3'd5;
    localparam logic [2:0] WR_B  = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    localparam logic signed [DW-1:0] MAX_INIT = {1'b1, {(DW-1){1'b0}}};

    logic [2:0]           state;
    logic [2:0]           state_nx;
    logic [IW-1:0]        i;
    logic [IW-1:0]        i_nx;
    logic signed [DW-1:0] data_reg;
    logic                 wr_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RD_A;
            RD_A:    state_nx = CAP_A;
            CAP_A:   state_nx = WR_A;
            WR_A:    state_nx = RD_B;
            RD_B:    state_nx = CAP_B;
            CAP_B:   state_nx = WR_B;
            WR_B:    state_nx = (i == IW'(MAP_PIX - 1)) ? DONE : RD_A;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The counter naturally wraps to 0 as the last pair leaves WR_B.
    assign i_nx  = (state == WR_B) ? i + 1'b1 : i;
    assign wr_nx = (state_nx == WR_A) || (state_nx == WR_B);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            i        <= '0;
            data_reg <= '0;
        end else begin
            state <= state_nx;
            i     <= i_nx;
            if (state == CAP_A || state == CAP_B)
                data_reg <= mem.cdata_rd;
        end
    end

    // Outputs are decoded from the next state and registered, so each one is
    // a clean flop output aligned with the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            mem.crd      <= 1'b0;
            mem.caddr_rd <= '0;
            mem.cwr      <= 1'b0;
            mem.caddr_wr <= '0;
            mem.cdata_wr <= '0;
            mem.csel     <= 3'd0;
        end else begin
            busy         <= (state_nx != IDLE);
            done         <= (state_nx == DONE);
            mem.crd      <= (state_nx == RD_A) || (state_nx == RD_B);
            mem.caddr_rd <= ((state_nx == RD_A) || (state_nx == RD_B)) ? AW'(i_nx) : '0;
            mem.cwr      <= wr_nx;
            mem.cdata_wr <= wr_nx ? mem.cdata_rd : '0;
            case (state_nx)
                WR_A:    mem.caddr_wr <= AW'({i_nx, 1'b0});
                WR_B:    mem.caddr_wr <= AW'({i_nx, 1'b1});
                default: mem.caddr_wr <= '0;
            endcase
            case (state_nx)
                RD_A, CAP_A: mem.csel <= SEL_K0;
                RD_B, CAP_B: mem.csel <= SEL_K1;
                WR_A, WR_B:  mem.csel <= SEL_OUT;
                default:     mem.csel <= 3'd0;
            endcase
        end
    end

    // Strict greater-than keeps the earliest address on ties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_val <= MAX_INIT;
            max_idx <= '0;
        end else if (state == IDLE && start) begin
            max_val <= MAX_INIT;
            max_idx <= '0;
        end else if ((state == WR_A || state == WR_B) && (data_reg > max_val)) begin
            max_val <= data_reg;
            max_idx <= mem.caddr_wr;
        end
    end

endmodule
